// File: rtl/mem_copy_dma_pkg.sv
// rtl/mem_copy_dma_pkg.sv - shared state encoding for the mem_copy_dma block and its bench
package mem_copy_dma_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t READ  = 2'd1;
    localparam state_t WRITE = 2'd2;
    localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - word-by-word memory copy engine with optional fill mode
//
// Optional feature: define MEM_COPY_DMA_FILL_EN to add the fill / fill_word ports.
//
// Ports:
//   clk, reset          single clock, asynchronous active-high reset
//   start, src, dst,    transfer request; src/dst/len sampled when start is accepted in IDLE
//   len
//   fill, fill_word     (fill build only) write fill_word to dst..dst+len-1, no reads
//   busy, done          busy during READ/WRITE; done pulses one cycle on clean completion
//   error, err_addr     sticky fault flag and faulting address, cleared by the next accepted start
//   rd, wr, addr, wdata data memory request, all combinational from the state
//   rdata, accessable   data memory response, combinational in the same cycle as the request
module mem_copy_dma
    import mem_copy_dma_pkg::*;
#(
    parameter int LEN_W = 16
`ifdef MEM_COPY_DMA_FILL_EN
    ,
    parameter logic [31:0] FILL_WORD = 32'h0000_0000
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
`ifdef MEM_COPY_DMA_FILL_EN
    input  logic             fill,
    input  logic [31:0]      fill_word,
`endif
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      err_addr,
    output logic             rd,
    output logic             wr,
    output logic [31:0]      addr,
    output logic [31:0]      wdata,
    input  logic [31:0]      rdata,
    input  logic             accessable
);

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [31:0]      data_q, data_d;
    logic             error_q, error_d;
    logic [31:0]      err_addr_q, err_addr_d;

    logic             start_acc;
    logic             start_fill;
    logic             fill_mode;
    logic [31:0]      fill_data;
    logic [LEN_W:0]   idx_inc;
    logic             last_word;

`ifdef MEM_COPY_DMA_FILL_EN
    logic             fill_q, fill_d;
    logic [31:0]      fill_word_q, fill_word_d;

    assign start_fill = fill;
    assign fill_mode  = fill_q;
    assign fill_data  = fill_word_q;

    always_comb begin
        fill_d      = fill_q;
        fill_word_d = fill_word_q;
        if (start_acc) begin
            fill_d      = fill;
            fill_word_d = fill_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_q      <= 1'b0;
            fill_word_q <= FILL_WORD;
        end else begin
            fill_q      <= fill_d;
            fill_word_q <= fill_word_d;
        end
    end
`else
    assign start_fill = 1'b0;
    assign fill_mode  = 1'b0;
    assign fill_data  = 32'h0;
`endif

    assign start_acc = (state_q == IDLE) && start;

    // One bit wider than the index so len at its maximum value cannot wrap the compare.
    assign idx_inc   = {1'b0, idx_q} + (LEN_W + 1)'(1);
    assign last_word = (idx_inc == {1'b0, len_q});

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            src_q      <= 32'h0;
            dst_q      <= 32'h0;
            len_q      <= '0;
            idx_q      <= '0;
            data_q     <= 32'h0;
            error_q    <= 1'b0;
            err_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0)      state_d = DONE;
                    else if (start_fill) state_d = WRITE;
                    else                 state_d = READ;
                end
            end
            READ:  state_d = accessable ? WRITE : IDLE;
            WRITE: begin
                if (!accessable)    state_d = IDLE;
                else if (last_word) state_d = DONE;
                else if (fill_mode) state_d = WRITE;
                else                state_d = READ;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: request capture, word index, read data and fault capture
    always_comb begin
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        idx_d      = idx_q;
        data_d     = data_q;
        error_d    = error_q;
        err_addr_d = err_addr_q;
        if (start_acc) begin
            src_d      = src;
            dst_d      = dst;
            len_d      = len;
            idx_d      = '0;
            error_d    = 1'b0;
            err_addr_d = 32'h0;
        end
        if (state_q == READ) begin
            data_d = rdata;
        end
        if (state_q == WRITE && accessable) begin
            idx_d = idx_q + LEN_W'(1);
        end
        if ((state_q == READ || state_q == WRITE) && !accessable) begin
            error_d    = 1'b1;
            err_addr_d = addr;
        end
    end

    // Outputs decoded from the current state only, so reset silences the bus at once
    always_comb begin
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            READ: begin
                rd   = 1'b1;
                busy = 1'b1;
                addr = src_q + 32'(idx_q);
            end
            WRITE: begin
                wr    = 1'b1;
                busy  = 1'b1;
                addr  = dst_q + 32'(idx_q);
                wdata = fill_mode ? fill_data : data_q;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign error    = error_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb/tb_mem_copy_dma.sv - self-checking bench for mem_copy_dma with a 256-word data memory
module tb_mem_copy_dma;
    import mem_copy_dma_pkg::*;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      src, dst;
    logic [LEN_W-1:0] len;
`ifdef MEM_COPY_DMA_FILL_EN
    logic             fill;
    logic [31:0]      fill_word;
`endif
    logic             busy, done, error, rd, wr, accessable;
    logic [31:0]      err_addr, addr, wdata, rdata;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    always #5 clk = ~clk;

    mem_copy_dma #(.LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
`ifdef MEM_COPY_DMA_FILL_EN
        .fill(fill), .fill_word(fill_word),
`endif
        .busy(busy), .done(done), .error(error), .err_addr(err_addr),
        .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata), .accessable(accessable)
    );

    assign accessable = (addr < 32'd256);
    assign rdata      = mem[addr[7:0]];

    always @(posedge clk) begin
        if (wr && accessable) mem[addr[7:0]] <= wdata;
    end

    typedef struct packed {
        state_t      ph;
        logic        rd, wr, busy, done, error;
        logic [31:0] addr, wdata, err_addr;
    } exp_t;

    exp_t        exp_q [$];
    logic        last_err;
    logic [31:0] last_err_addr;
    int          n_chk, n_pass;
    int          cyc, busy_cnt, done_cnt, done_cyc, rdwr_cnt;

    function automatic void check(string name, logic [127:0] act, logic [127:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endfunction

    task automatic fault(input logic [31:0] a);
        exp_t e;
        e = '0; e.ph = IDLE; e.error = 1'b1; e.err_addr = a;
        exp_q.push_back(e);
    endtask

    // Expected per-cycle bus trace of one transfer, with the reference memory updated
    // in ascending order so overlapping copies follow forward-copy semantics.
    task automatic build(input logic [31:0] s, input logic [31:0] d, input int n,
                         input bit f, input logic [31:0] fw, input int maxw);
        exp_t e;
        int w;
        logic [31:0] a, v;
        w = 0;
        v = 32'h0;
        if (n == 0) begin
            e = '0; e.ph = DONE; e.done = 1'b1;
            exp_q.push_back(e);
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (!f) begin
                a = s + 32'(i);
                e = '0; e.ph = READ; e.busy = 1'b1; e.rd = 1'b1; e.addr = a;
                exp_q.push_back(e);
                if (a >= 32'd256) begin fault(a); return; end
                v = ref_mem[a[7:0]];
            end else begin
                v = fw;
            end
            a = d + 32'(i);
            e = '0; e.ph = WRITE; e.busy = 1'b1; e.wr = 1'b1; e.addr = a; e.wdata = v;
            exp_q.push_back(e);
            if (a >= 32'd256) begin fault(a); return; end
            if (w < maxw) begin ref_mem[a[7:0]] = v; w++; end
        end
        e = '0; e.ph = DONE; e.done = 1'b1;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            last_err      = e.error;
            last_err_addr = e.err_addr;
        end else begin
            e = '0; e.ph = IDLE; e.error = last_err; e.err_addr = last_err_addr;
        end
        check($sformatf("bus_cyc%0d_ph%0d", cyc, e.ph),
              {rd, wr, busy, done, error, addr, wdata, err_addr},
              {e.rd, e.wr, e.busy, e.done, e.error, e.addr, e.wdata, e.err_addr});
        if (busy) busy_cnt++;
        if (rd || wr) rdwr_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; end
    end

    task automatic launch(input logic [31:0] s, input logic [31:0] d, input int n,
                          input bit f, input logic [31:0] fw, input int maxw);
        @(posedge clk); #1;
        src = s; dst = d; len = n[LEN_W-1:0]; start = 1'b1;
`ifdef MEM_COPY_DMA_FILL_EN
        fill = f; fill_word = fw;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; busy_cnt = 0; done_cnt = 0; done_cyc = 0; rdwr_cnt = 0;
        build(s, d, n, f, fw, maxw);
    endtask

    task automatic check_image(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check(name, bad, 0);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; last_err = 1'b0; last_err_addr = 32'h0;
        cyc = 0; busy_cnt = 0; done_cnt = 0; done_cyc = 0; rdwr_cnt = 0;
        reset = 1'b1; start = 1'b0; src = 32'h0; dst = 32'h0; len = '0;
`ifdef MEM_COPY_DMA_FILL_EN
        fill = 1'b0; fill_word = 32'h0;
`endif
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {rd, wr, busy, done, error, addr, wdata, err_addr}, '0);
        reset = 1'b0;

        // Copy 4 words 0..3 -> 100..103
        launch(32'd0, 32'd100, 4, 1'b0, 32'h0, 1000);
        repeat (12) @(posedge clk);
        #1;
        check("copy_done_cycle", done_cyc, 9);
        check("copy_busy_cycles", busy_cnt, 8);
        check("copy_done_count", done_cnt, 1);
        for (int i = 0; i < 4; i++) check($sformatf("copy_mem%0d", 100 + i), mem[100 + i], 32'(i + 1));
        check_image("copy_image");

        // Zero length
        launch(32'd5, 32'd6, 0, 1'b0, 32'h0, 1000);
        repeat (4) @(posedge clk);
        #1;
        check("zero_done_cycle", done_cyc, 1);
        check("zero_busy_cycles", busy_cnt, 0);
        check("zero_rdwr_cycles", rdwr_cnt, 0);

        // Read fault at address 256
        launch(32'd254, 32'd10, 4, 1'b0, 32'h0, 1000);
        repeat (12) @(posedge clk);
        #1;
        check("err_flag", error, 1);
        check("err_addr", err_addr, 32'd256);
        check("err_done_count", done_cnt, 0);
        check("err_mem10", mem[10], 32'h1000_00FE);
        check("err_mem11", mem[11], 32'h1000_00FF);
        check("err_mem12", mem[12], 32'h1000_000C);
        check_image("err_image");

        // Reset during the third WRITE of an 8-word copy
        launch(32'd30, 32'd40, 8, 1'b0, 32'h0, 2);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        last_err = 1'b0; last_err_addr = 32'h0;
        #1;
        check("rst_rd_wr", {rd, wr}, 2'b00);
        @(posedge clk); #1;
        check("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem40", mem[40], 32'h1000_001E);
        check("rst_mem41", mem[41], 32'h1000_001F);
        check("rst_mem42", mem[42], 32'h1000_002A);
        check_image("rst_image");

        // Second start three cycles into a transfer is ignored
        launch(32'd0, 32'd200, 4, 1'b0, 32'h0, 1000);
        @(posedge clk);
        @(posedge clk); #1;
        src = 32'd50; dst = 32'd210; len = LEN_W'(2); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("busy_start_done_count", done_cnt, 1);
        check("busy_start_done_cycle", done_cyc, 9);
        check("busy_start_mem203", mem[203], 32'd4);
        check("busy_start_mem210", mem[210], 32'h1000_00D2);
        check_image("busy_start_image");

`ifdef MEM_COPY_DMA_FILL_EN
        // Fill 3 words at 20
        launch(32'd0, 32'd20, 3, 1'b1, 32'hDEAD_BEEF, 1000);
        repeat (8) @(posedge clk);
        #1;
        fill = 1'b0;
        check("fill_done_cycle", done_cyc, 4);
        check("fill_busy_cycles", busy_cnt, 3);
        for (int i = 0; i < 3; i++) check($sformatf("fill_mem%0d", 20 + i), mem[20 + i], 32'hDEAD_BEEF);
        check_image("fill_image");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
